// File: rtl/fetch_unit.sv
// fetch_unit: RV32 instruction-fetch front end with an in-order request queue feeding IF/ID.
// Latency: request handshake in cycle N, zero-wait response in N+1, valid_D high from N+2.
// Backpressure: responses are never back-pressured; they are buffered while Decode is stalled.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stallF, stallD, flushD      hazard-unit controls for the F and D stages
//   br_en_E, br_target_E        Execute-stage redirect
//   imem_req_*                  instruction memory request (valid/ready, address = fetch PC)
//   imem_rsp_*                  in-order instruction responses
//   instr_D, pc_D, pc_plus4_D,
//   valid_D                     IF/ID pipeline register
//   fetch_busy                  Decode takes a bubble because no instruction is ready
// Optional feature: define FETCH_PERF_CNT_EN to add perf_bubble_cnt / perf_kill_cnt.
module fetch_unit #(
  parameter int               XLEN            = 32,
  parameter logic [XLEN-1:0]  RESET_PC        = '0,
  parameter int               MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             br_en_E,
  input  logic [XLEN-1:0]  br_target_E,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      instr_D,
  output logic [XLEN-1:0]  pc_D,
  output logic [XLEN-1:0]  pc_plus4_D,
  output logic             valid_D,
  output logic             fetch_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_bubble_cnt,
  output logic [31:0]      perf_kill_cnt
`endif
);

  localparam int             PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int             CW    = PW + 1;
  localparam logic [CW-1:0]  DEPTH = CW'(MAX_OUTSTANDING);
  localparam logic [31:0]    NOP   = 32'h0000_0013;

  // Queue bookkeeping: entries are in order from head_q; the first fcnt_q of the
  // cnt_q allocated entries hold a response, the rest still await one.
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [PW-1:0]   head_q, head_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [CW-1:0]   kill_q, kill_d;
  logic [XLEN-1:0] ent_pc_q    [MAX_OUTSTANDING];
  logic [31:0]     ent_instr_q [MAX_OUTSTANDING];

  logic [PW-1:0]   tail_idx, fill_idx;
  logic [CW-1:0]   unfilled;
  logic            kill_act, rsp_live, head_filled, bypass, head_rdy;
  logic            d_upd, pop, hs;
  logic [31:0]     head_instr;

  assign tail_idx    = head_q + cnt_q[PW-1:0];
  assign fill_idx    = head_q + fcnt_q[PW-1:0];
  assign unfilled    = cnt_q - fcnt_q;
  assign kill_act    = (kill_q != '0);
  // A response is live only if it belongs to a request that survived every redirect.
  assign rsp_live    = imem_rsp_valid && !kill_act && !br_en_E && (unfilled != '0);
  assign head_filled = (fcnt_q != '0);
  // With no filled entries, a live response necessarily fills the head entry.
  assign bypass      = rsp_live && (fcnt_q == '0);
  assign head_rdy    = head_filled || bypass;
  assign head_instr  = head_filled ? ent_instr_q[head_q] : imem_rsp_data;

  assign d_upd       = !flushD && !br_en_E && !stallD;
  assign pop         = d_upd && head_rdy;
  assign fetch_busy  = d_upd && !head_rdy;

  // rst_n gates the request so nothing is offered while the block is held in reset.
  assign imem_req_valid = rst_n && !stallF && !br_en_E && (cnt_q < DEPTH) && !kill_act;
  assign imem_req_addr  = pc_f_q;
  assign hs             = imem_req_valid && imem_req_ready;

  always_comb begin
    pc_f_d = pc_f_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    fcnt_d = fcnt_q;
    kill_d = kill_q;
    if (br_en_E) begin
      pc_f_d = br_target_E;
      head_d = '0;
      cnt_d  = '0;
      fcnt_d = '0;
      // Every request still outstanding at memory gets killed, except the one
      // whose response lands right now (it is simply ignored).
      kill_d = kill_q + unfilled - CW'(imem_rsp_valid);
    end else begin
      if (hs) pc_f_d = pc_f_q + XLEN'(4);
      head_d = head_q + PW'(pop);
      cnt_d  = cnt_q + CW'(hs) - CW'(pop);
      fcnt_d = fcnt_q + CW'(rsp_live) - CW'(pop);
      if (kill_act && imem_rsp_valid) kill_d = kill_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q <= RESET_PC;
      head_q <= '0;
      cnt_q  <= '0;
      fcnt_q <= '0;
      kill_q <= '0;
    end else begin
      pc_f_q <= pc_f_d;
      head_q <= head_d;
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      kill_q <= kill_d;
    end
  end

  // Entry payload is qualified by cnt_q/fcnt_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (hs)       ent_pc_q[tail_idx]    <= pc_f_q;
    if (rsp_live) ent_instr_q[fill_idx] <= imem_rsp_data;
  end

  // IF/ID register: flush/redirect beats stall, stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_D    <= 1'b0;
      instr_D    <= NOP;
      pc_D       <= RESET_PC;
      pc_plus4_D <= RESET_PC + XLEN'(4);
    end else if (flushD || br_en_E) begin
      valid_D <= 1'b0;
      instr_D <= NOP;
    end else if (!stallD) begin
      if (head_rdy) begin
        valid_D    <= 1'b1;
        instr_D    <= head_instr;
        pc_D       <= ent_pc_q[head_q];
        pc_plus4_D <= ent_pc_q[head_q] + XLEN'(4);
      end else begin
        valid_D <= 1'b0;
        instr_D <= NOP;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
      perf_kill_cnt   <= '0;
    end else begin
      if (fetch_busy) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      // Dropped = response for a killed request, or one landing during a redirect.
      if (imem_rsp_valid && (kill_act || br_en_E)) perf_kill_cnt <= perf_kill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit against a queue-based fetch-stream model.
// Latency: memory model answers a configurable number of cycles after each handshake.
// Backpressure: imem_req_ready driven by the directed scenarios.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, br_en_E = 1'b0;
  logic [31:0] br_target_E = '0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] instr_D, pc_D, pc_plus4_D;
  logic        valid_D, fetch_busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt, perf_kill_cnt;
`endif

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .br_en_E(br_en_E), .br_target_E(br_target_E),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_D(instr_D), .pc_D(pc_D),
    .pc_plus4_D(pc_plus4_D), .valid_D(valid_D), .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_CNT_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_kill_cnt(perf_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13} ^ 32'h5A00_0000;
  endfunction

  // ---------------- instruction memory model ----------------
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      cyc = cyc + 1;
      #1;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq_addr[0]);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  // ---------------- fetch-stream model ----------------
  // Stream = PCs requested and not yet delivered nor discarded, each with an
  // "answered" flag; m_kill = requests still at memory whose answer must be dropped.
  logic [31:0] m_pc, m_i, m_p;
  logic        m_v;
  logic [31:0] s_pc[$];
  bit          s_arr[$];
  int          m_kill;
  logic [31:0] m_bub, m_kc;

  always @(negedge clk) begin
    bit exp_rv, live, front_rdy, upd, exp_busy;
    int unarr;
    if (!rst_n) begin
      m_pc = 32'h0; m_v = 1'b0; m_i = NOP; m_p = 32'h0;
      s_pc.delete(); s_arr.delete(); m_kill = 0; m_bub = '0; m_kc = '0;
      mq_addr.delete(); mq_due.delete();
      chk("rst_valid_D", {31'b0, valid_D}, 32'h0);
      chk("rst_instr_D", instr_D, NOP);
      chk("rst_pc_D", pc_D, 32'h0);
      chk("rst_pc_plus4_D", pc_plus4_D, 32'h4);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    end else begin
      chk("m_valid_D", {31'b0, valid_D}, {31'b0, m_v});
      chk("m_instr_D", instr_D, m_i);
      chk("m_pc_D", pc_D, m_p);
      chk("m_pc_plus4_D", pc_plus4_D, m_p + 32'd4);
`ifdef FETCH_PERF_CNT_EN
      chk("m_perf_bubble", perf_bubble_cnt, m_bub);
      chk("m_perf_kill", perf_kill_cnt, m_kc);
`endif
      exp_rv = !stallF && !br_en_E && (s_pc.size() < 2) && (m_kill == 0);
      chk("m_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv) chk("m_req_addr", imem_req_addr, m_pc);
      live      = imem_rsp_valid && (m_kill == 0) && !br_en_E;
      front_rdy = (s_pc.size() > 0) && (s_arr[0] || live);
      upd       = !stallD && !flushD && !br_en_E;
      exp_busy  = upd && !front_rdy;
      chk("m_fetch_busy", {31'b0, fetch_busy}, {31'b0, exp_busy});

      if (flushD || br_en_E) begin
        m_v = 1'b0; m_i = NOP;
      end else if (!stallD) begin
        if (front_rdy) begin
          m_v = 1'b1; m_p = s_pc[0]; m_i = mem_word(s_pc[0]);
        end else begin
          m_v = 1'b0; m_i = NOP;
        end
      end

      unarr = 0;
      foreach (s_arr[k]) if (!s_arr[k]) unarr++;
      if (br_en_E) begin
        m_kill = m_kill + unarr - (imem_rsp_valid ? 1 : 0);
        if (imem_rsp_valid) m_kc = m_kc + 32'd1;
        s_pc.delete(); s_arr.delete();
        m_pc = br_target_E;
      end else begin
        if (imem_rsp_valid) begin
          if (m_kill > 0) begin
            m_kill--; m_kc = m_kc + 32'd1;
          end else begin
            for (int k = 0; k < s_arr.size(); k++)
              if (!s_arr[k]) begin s_arr[k] = 1'b1; break; end
          end
        end
        if (upd && front_rdy) begin
          void'(s_pc.pop_front()); void'(s_arr.pop_front());
        end
        if (exp_rv && imem_req_ready) begin
          s_pc.push_back(m_pc); s_arr.push_back(1'b0); m_pc = m_pc + 32'd4;
        end
      end
      if (exp_busy) m_bub = m_bub + 32'd1;

      if (imem_rsp_valid && mq_addr.size() > 0) begin
        void'(mq_addr.pop_front()); void'(mq_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr); mq_due.push_back(cyc + lat);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Leaves the caller at +1 of cycle 0 after release.
  task automatic do_reset(input int latency);
    rst_n = 1'b0;
    stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; br_en_E = 1'b0;
    br_target_E = '0; imem_req_ready = 1'b1; lat = latency;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic skip(input int n);
    repeat (n) next_cycle();
  endtask

  initial begin
    // S1: zero-wait streaming after reset
    do_reset(1);
    #2 chk("s1_c0_req_vld", {31'b0, imem_req_valid}, 32'h1);
    chk("s1_c0_addr", imem_req_addr, 32'h0);
    next_cycle(); #2 chk("s1_c1_addr", imem_req_addr, 32'h4);
    chk("s1_c1_valid_D", {31'b0, valid_D}, 32'h0);
    next_cycle(); #2 chk("s1_c2_addr", imem_req_addr, 32'h8);
    chk("s1_c2_valid_D", {31'b0, valid_D}, 32'h1);
    chk("s1_c2_pc_D", pc_D, 32'h0);
    chk("s1_c2_instr_D", instr_D, 32'h5A00_0013);
    next_cycle(); #2 chk("s1_c3_pc_D", pc_D, 32'h4);
    next_cycle(); #2 chk("s1_c4_pc_D", pc_D, 32'h8);

    // S2: stallD for 3 cycles, responses keep arriving
    do_reset(1);
    skip(3); stallD = 1'b1;
    next_cycle(); #2 chk("s2_c4_pc_D", pc_D, 32'h4);
    chk("s2_c4_valid_D", {31'b0, valid_D}, 32'h1);
    next_cycle(); #2 chk("s2_c5_pc_D", pc_D, 32'h4);
    next_cycle(); stallD = 1'b0;
    #2 chk("s2_c6_pc_D", pc_D, 32'h4);
    next_cycle(); #2 chk("s2_c7_pc_D", pc_D, 32'h8);
    next_cycle(); #2 chk("s2_c8_pc_D", pc_D, 32'hC);
    chk("s2_c8_valid_D", {31'b0, valid_D}, 32'h1);

    // S3: 3-cycle memory, redirect with two requests outstanding
    do_reset(3);
    skip(2); br_en_E = 1'b1; br_target_E = 32'h100;
    #2 chk("s3_br_req_vld", {31'b0, imem_req_valid}, 32'h0);
    next_cycle(); br_en_E = 1'b0;
    #2 chk("s3_c3_req_vld", {31'b0, imem_req_valid}, 32'h0);
    skip(2); #2 chk("s3_c5_req_vld", {31'b0, imem_req_valid}, 32'h1);
    chk("s3_c5_addr", imem_req_addr, 32'h100);
    skip(3); #2 chk("s3_c8_valid_D", {31'b0, valid_D}, 32'h0);
    next_cycle(); #2 chk("s3_c9_valid_D", {31'b0, valid_D}, 32'h1);
    chk("s3_c9_pc_D", pc_D, 32'h100);
    chk("s3_c9_instr_D", instr_D, mem_word(32'h100));
`ifdef FETCH_PERF_CNT_EN
    chk("s3_perf_kill", perf_kill_cnt, 32'd2);
`endif

    // S4: stallD+flushD together, then zero-wait redirect timing
    do_reset(1);
    skip(4); stallD = 1'b1; flushD = 1'b1;
    next_cycle(); stallD = 1'b0; flushD = 1'b0;
    #2 chk("s4_flush_valid_D", {31'b0, valid_D}, 32'h0);
    chk("s4_flush_instr_D", instr_D, NOP);
    chk("s4_flush_pc_D", pc_D, 32'h8);
    next_cycle(); br_en_E = 1'b1; br_target_E = 32'h200; stallF = 1'b1;
    next_cycle(); br_en_E = 1'b0; stallF = 1'b0;
    #2 chk("s4_r1_req_vld", {31'b0, imem_req_valid}, 32'h1);
    chk("s4_r1_addr", imem_req_addr, 32'h200);
    next_cycle(); #2 chk("s4_r2_valid_D", {31'b0, valid_D}, 32'h0);
    next_cycle(); #2 chk("s4_r3_valid_D", {31'b0, valid_D}, 32'h1);
    chk("s4_r3_pc_D", pc_D, 32'h200);
    chk("s4_r3_pc_plus4_D", pc_plus4_D, 32'h204);

    // S5: memory not ready for 4 cycles
    do_reset(1);
    skip(3); imem_req_ready = 1'b0;
    #2 chk("s5_c3_addr", imem_req_addr, 32'hC);
    for (int k = 4; k <= 6; k++) begin
      next_cycle(); #2 chk("s5_hold_addr", imem_req_addr, 32'hC);
      chk("s5_hold_vld", {31'b0, imem_req_valid}, 32'h1);
    end
    chk("s5_busy", {31'b0, fetch_busy}, 32'h1);
    chk("s5_valid_D", {31'b0, valid_D}, 32'h0);
    next_cycle(); imem_req_ready = 1'b1;

    // S6: reset mid-stream with two requests outstanding
    do_reset(3);
    skip(5);
    chk("s6_pre_valid_D", {31'b0, valid_D}, 32'h1);
    chk("s6_pre_pc_D", pc_D, 32'h4);
    #1 rst_n = 1'b0;
    #1 chk("s6_rst_valid_D", {31'b0, valid_D}, 32'h0);
    chk("s6_rst_instr_D", instr_D, NOP);
    chk("s6_rst_pc_D", pc_D, 32'h0);
    chk("s6_rst_pc_plus4_D", pc_plus4_D, 32'h4);
    chk("s6_rst_req_vld", {31'b0, imem_req_valid}, 32'h0);
    do_reset(3);
    #2 chk("s6_post_req_vld", {31'b0, imem_req_valid}, 32'h1);
    chk("s6_post_addr", imem_req_addr, 32'h0);
    skip(4); #2 chk("s6_post_pc_D", pc_D, 32'h0);
    chk("s6_post_instr_D", instr_D, mem_word(32'h0));
    next_cycle(); #2 chk("s6_post_pc_D2", pc_D, 32'h4);

    skip(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
